// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: controller step encoding and the architectural reset PC.
package lc3_pkg;

  typedef enum logic [3:0] {
    CNTRL_UPDATE_PC   = 4'd0,
    CNTRL_FETCH       = 4'd1,
    CNTRL_DECODE      = 4'd2,
    CNTRL_EXECUTE     = 4'd3,
    CNTRL_UPDATE_REGF = 4'd4,
    CNTRL_COMPUTE_PC  = 4'd5,
    CNTRL_COMPUTE_MEM = 4'd6,
    CNTRL_READ_MEM    = 4'd7,
    CNTRL_IND_ADDR_RD = 4'd8,
    CNTRL_WRITE_MEM   = 4'd9
  } control_e;

  localparam logic [15:0] PC_RESET = 16'h3000;

endpackage

// File: rtl/fetch_interface.sv
// Signal bundle between the fetch stage, its driver and a passive input monitor.
interface fetch_interface #(
  parameter int ADDR_W = 16
) (
  input logic clk
);

  logic              reset;
  logic              enable_updatePC;
  logic              enable_fetch;
  logic              br_taken;
  logic [ADDR_W-1:0] taddr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic              instrmem_rd;

  modport fetch_dut (
    input  clk, reset, enable_updatePC, enable_fetch, br_taken, taddr,
    output pc, npc, instrmem_rd
  );

  modport fetch_tb (
    input  clk, pc, npc, instrmem_rd,
    output reset, enable_updatePC, enable_fetch, br_taken, taddr
  );

  modport fetch_monitor (
    input clk, reset, enable_updatePC, enable_fetch, br_taken, taddr
  );

endinterface

// File: rtl/fetch_dut.sv
// LC-3 fetch stage: program counter with sequential/branch update and an
// instruction-memory read strobe gated by reset.
module fetch_dut #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(lc3_pkg::PC_RESET)
) (
  fetch_interface.fetch_dut fif
);

  import lc3_pkg::*;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] npc;

  // Wraps naturally modulo 2^ADDR_W.
  assign npc = pc_q + ADDR_W'(1);

  always_comb begin
    pc_d = pc_q;
    if (fif.enable_updatePC) begin
      pc_d = fif.br_taken ? fif.taddr : npc;
    end
  end

  always_ff @(posedge fif.clk or negedge fif.reset) begin
    if (!fif.reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign fif.pc          = pc_q;
  assign fif.npc         = npc;
  assign fif.instrmem_rd = fif.reset & fif.enable_fetch;

  a_ctrl_known : assert property (
    @(posedge fif.clk) disable iff (!fif.reset)
      !$isunknown({fif.enable_updatePC, fif.br_taken})
  );

endmodule

// File: tb/tb_fetch_dut.sv
// Bench for fetch_dut: directed literal checks plus randomized traffic compared
// every cycle against a behavioural PC model.
module tb_fetch_dut;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  int   m_pc   = 0;

  fetch_interface #(.ADDR_W(16)) fif (.clk(clk));

  fetch_dut #(.ADDR_W(16), .PC_RESET(16'h3000)) dut (.fif(fif.fetch_dut));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: pc as a plain integer, reset dominates, update on edge.
  always @(posedge clk or negedge fif.reset) begin
    if (!fif.reset)                m_pc <= 'h3000;
    else if (fif.enable_updatePC)  m_pc <= fif.br_taken ? int'(fif.taddr) : (m_pc + 1) % 65536;
  end

  always @(negedge clk) begin
    check("model_pc",  int'(fif.pc),  m_pc);
    check("model_npc", int'(fif.npc), (m_pc + 1) % 65536);
    check("model_rd",  int'(fif.instrmem_rd), (fif.reset && fif.enable_fetch) ? 1 : 0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    fif.reset           = 1'b1;
    fif.enable_updatePC = 1'b0;
    fif.enable_fetch    = 1'b0;
    fif.br_taken        = 1'b0;
    fif.taddr           = '0;
    #1 fif.reset = 1'b0;
    #1;
    check("reset_pc",  int'(fif.pc),  'h3000);
    check("reset_npc", int'(fif.npc), 'h3001);
    check("reset_rd",  int'(fif.instrmem_rd), 0);
    fif.enable_updatePC = 1'b1;
    fif.enable_fetch    = 1'b1;
    step();
    step();
    check("reset_hold_pc", int'(fif.pc), 'h3000);
    check("reset_rd_gate", int'(fif.instrmem_rd), 0);
    fif.enable_updatePC = 1'b0;
    fif.enable_fetch    = 1'b0;
    fif.reset           = 1'b1;
    step();
    check("first_edge_no_upd", int'(fif.pc), 'h3000);

    fif.enable_updatePC = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", int'(fif.pc), 'h3000 + int'(i));
    end

    fif.br_taken = 1'b1;
    fif.taddr    = 16'h4ABC;
    step();
    check("branch_pc",  int'(fif.pc),  'h4ABC);
    check("branch_npc", int'(fif.npc), 'h4ABD);
    fif.enable_updatePC = 1'b0;
    fif.taddr           = 16'h1234;
    step();
    check("branch_hold", int'(fif.pc), 'h4ABC);

    fif.br_taken = 1'b0;
    begin
      logic [3:0] pat;
      pat = 4'b0110;
      for (int unsigned i = 0; i < 4; i++) begin
        fif.enable_fetch = pat[3-i];
        #1;
        check("fetch_rd", int'(fif.instrmem_rd), int'(pat[3-i]));
        check("fetch_pc", int'(fif.pc), 'h4ABC);
        step();
      end
    end

    fif.enable_updatePC = 1'b1;
    fif.br_taken        = 1'b1;
    fif.taddr           = 16'hFFFF;
    step();
    check("wrap_pc",  int'(fif.pc),  'hFFFF);
    check("wrap_npc", int'(fif.npc), 'h0000);
    fif.br_taken = 1'b0;
    step();
    check("wrap_seq_pc", int'(fif.pc), 'h0000);

    fif.br_taken = 1'b1;
    fif.taddr    = 16'h4ABC;
    step();
    fif.enable_fetch = 1'b1;
    fif.reset        = 1'b0;
    #1;
    check("midrst_pc", int'(fif.pc), 'h3000);
    check("midrst_rd", int'(fif.instrmem_rd), 0);
    step();
    check("midrst_hold", int'(fif.pc), 'h3000);
    fif.reset = 1'b1;

    for (int unsigned n = 0; n < 600; n++) begin
      step();
      fif.reset           = ($urandom_range(31) != 0);
      fif.enable_updatePC = 1'($urandom);
      fif.enable_fetch    = 1'($urandom);
      fif.br_taken        = ($urandom_range(3) == 0);
      fif.taddr           = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
    end
    fif.reset = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_dut.md
FETCH_DUT -- requirements
Module: fetch_dut

Interface
REQ-001 Parameter ADDR_W, default 16, width of pc, npc and taddr.
REQ-002 Parameter PC_RESET, default 16'h3000, value loaded into pc on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 enable_updatePC  input  1  when 1, pc loads its next value at the rising edge.
REQ-006 enable_fetch  input  1  when 1, an instruction-memory read is requested.
REQ-007 br_taken  input  1  selects taddr (1) or npc (0) as next pc.
REQ-008 taddr  input  ADDR_W  branch/jump target address.
REQ-009 pc  output  ADDR_W  current program counter; drives instruction-memory address.
REQ-010 npc  output  ADDR_W  pc+1.
REQ-011 instrmem_rd  output  1  instruction-memory read strobe.
REQ-012 All ports SHALL be grouped in interface fetch_interface (clk as its port), with modports fetch_dut, fetch_tb (drives inputs, samples outputs) and fetch_monitor (inputs only).

Function
REQ-013 pc SHALL be the only state register; npc and instrmem_rd SHALL be combinational.
REQ-014 At a rising clk with enable_updatePC=1 and br_taken=1, pc SHALL load taddr.
REQ-015 At a rising clk with enable_updatePC=1 and br_taken=0, pc SHALL load npc.
REQ-016 With enable_updatePC=0, pc SHALL hold; br_taken and taddr SHALL be ignored.
REQ-017 npc SHALL equal pc+1 modulo 2^ADDR_W (pc=16'hFFFF gives npc=16'h0000; next sequential pc=16'h0000).
REQ-018 instrmem_rd SHALL equal enable_fetch in the same cycle while reset is deasserted, and 0 otherwise; it never goes high-impedance.
REQ-019 enable_fetch SHALL NOT affect pc.
REQ-020 enable_fetch and enable_updatePC both 1: instrmem_rd=1 for the current pc and pc updates at the edge; no priority between them.
REQ-021 Any X on enable_updatePC or br_taken out of reset SHALL be flagged by an assertion.

Reset
REQ-022 On reset=0, pc SHALL become PC_RESET immediately (no clock needed); npc=PC_RESET+1; instrmem_rd=0.
REQ-023 Reset asserted mid-operation SHALL override any pending update; enable inputs SHALL have no effect while reset=0.
REQ-024 The first update after reset deassertion SHALL occur at the first rising clk with enable_updatePC=1.

Structure
REQ-025 Shared package lc3_pkg SHALL hold typedef control_e (CNTRL_UPDATE_PC=0, CNTRL_FETCH=1, CNTRL_DECODE=2, CNTRL_EXECUTE=3, CNTRL_UPDATE_REGF=4, CNTRL_COMPUTE_PC=5, CNTRL_COMPUTE_MEM=6, CNTRL_READ_MEM=7, CNTRL_IND_ADDR_RD=8, CNTRL_WRITE_MEM=9) and constant PC_RESET.
REQ-026 fetch_dut SHALL be flat (no sub-modules); the bench fetch_test SHALL be a program/module with stimulus, a reference model and a scoreboard comparing pc/npc/instrmem_rd every cycle.

Verification
REQ-027 Reset: reset=0 for 2 cycles -> pc=16'h3000, npc=16'h3001, instrmem_rd=0 before the first edge.
REQ-028 Sequential: enable_updatePC=1, br_taken=0 for 3 edges from 16'h3000 -> pc 16'h3001, 16'h3002, 16'h3003.
REQ-029 Branch: pc=16'h3002, br_taken=1, taddr=16'h4ABC, enable_updatePC=1 -> pc=16'h4ABC, npc=16'h4ABD next cycle; with enable_updatePC=0 the same stimulus leaves pc at 16'h3002.
REQ-030 Fetch strobe: enable_fetch toggled 0/1/1/0 -> instrmem_rd follows 0/1/1/0 combinationally, pc unchanged.
REQ-031 Wrap: taddr=16'hFFFF loaded, then one sequential update -> npc=16'h0000 then pc=16'h0000.
REQ-032 Reset mid-run: pc=16'h4ABC, reset=0 between edges -> pc=16'h3000 immediately, instrmem_rd=0 despite enable_fetch=1.
